// File: rtl/ex_pkg.sv
// Shared types and op-decode helpers for the sequential multiply/divide unit.
package ex_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'b000,
        MULTU = 3'b001,
        DIV   = 3'b010,
        DIVU  = 3'b011,
        MADD  = 3'b100,
        MADDU = 3'b101,
        MSUB  = 3'b110,
        MSUBU = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } muldiv_state_t;

    function automatic logic is_signed(input muldiv_op_t op);
        return (op == MULT) || (op == DIV) || (op == MADD) || (op == MSUB);
    endfunction

    function automatic logic is_div(input muldiv_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_acc(input muldiv_op_t op);
        return (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
    endfunction

    function automatic logic is_sub(input muldiv_op_t op);
        return (op == MSUB) || (op == MSUBU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: MUL_BPC-bit shift-add multiply step,
// or one restoring divide step, selected by i_div.
module muldiv_step #(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 2
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opb,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int PW = WIDTH + MUL_BPC;

    logic [PW-1:0]    w_pp;
    logic [PW-1:0]    w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_pp    = PW'(i_opb) * PW'(i_lo[MUL_BPC-1:0]);
        w_sum   = PW'(i_hi) + w_pp;
        w_shift = {i_hi, i_lo[WIDTH-1]};
        // remainder < divisor, so the true difference always fits in WIDTH bits
        w_diff  = w_shift[WIDTH-1:0] - i_opb;
        if (i_div) begin
            if (w_shift >= {1'b0, i_opb}) begin
                o_hi = w_diff;
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi = w_shift[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_hi = w_sum[PW-1:MUL_BPC];
            o_lo = {w_sum[MUL_BPC-1:0], i_lo[WIDTH-1:MUL_BPC]};
        end
    end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle multiply/divide unit with HI/LO accumulator for the EX stage.
//   state | meaning
//   IDLE  | waiting for Start; MTHI/MTLO writes accepted
//   CALC  | iterating the unsigned datapath, counter counts down to 0
//   FIXUP | sign correction and accumulate into Hi/Lo
//   DONE  | Done pulse, result visible; Start may launch the next op
module ex_muldiv_seq
    import ex_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 2
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    input  logic             HiWe,
    input  logic             LoWe,
    input  logic [WIDTH-1:0] HiIn,
    input  logic [WIDTH-1:0] LoIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivByZero
);
    localparam int N_MUL = WIDTH / MUL_BPC;
    localparam int CW    = $clog2(WIDTH + 1);

    muldiv_state_t    r_state;
    muldiv_op_t       r_op;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_wk_hi;
    logic [WIDTH-1:0] r_wk_lo;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    muldiv_op_t         w_op;
    logic               w_start;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_start_div0;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [CW-1:0]      w_cnt_init;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_hilo;
    logic [2*WIDTH-1:0] w_res;

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Hi        = r_hi;
    assign Lo        = r_lo;
    assign DivByZero = r_dbz;

    always_comb begin
        w_op         = muldiv_op_t'(Op);
        w_start      = Start && !Flush;
        w_a_neg      = is_signed(w_op) && A[WIDTH-1];
        w_b_neg      = is_signed(w_op) && B[WIDTH-1];
        w_a_mag      = w_a_neg ? -A : A;
        w_b_mag      = w_b_neg ? -B : B;
        w_start_div0 = is_div(w_op) && (B == '0);
        if (w_start_div0)
            w_cnt_init = '0;
        else if (is_div(w_op))
            w_cnt_init = CW'(WIDTH);
        else
            w_cnt_init = CW'(N_MUL);
    end

    muldiv_step #(
        .WIDTH   (WIDTH),
        .MUL_BPC (MUL_BPC)
    ) u_step (
        .i_div (is_div(r_op)),
        .i_hi  (r_wk_hi),
        .i_lo  (r_wk_lo),
        .i_opb (r_opb),
        .o_hi  (w_step_hi),
        .o_lo  (w_step_lo)
    );

    // Magnitude of MIN is 2^(WIDTH-1) unsigned, so MIN / -1 lands on MIN with no special case.
    always_comb begin
        w_prod   = {r_wk_hi, r_wk_lo};
        w_prod_s = r_neg_q ? -w_prod : w_prod;
        w_hilo   = {r_hi, r_lo};
        w_q      = r_neg_q ? -r_wk_lo : r_wk_lo;
        w_r      = r_neg_r ? -r_wk_hi : r_wk_hi;
        if (r_div0)
            w_res = {r_wk_lo, {WIDTH{1'b1}}};
        else if (is_div(r_op))
            w_res = {w_r, w_q};
        else if (is_acc(r_op))
            w_res = is_sub(r_op) ? (w_hilo - w_prod_s) : (w_hilo + w_prod_s);
        else
            w_res = w_prod_s;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
            r_op    <= MULT;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_wk_hi <= '0;
            r_wk_lo <= '0;
            r_opb   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (r_state == IDLE) begin
                        if (HiWe) r_hi <= HiIn;
                        if (LoWe) r_lo <= LoIn;
                    end
                    if (w_start) begin
                        r_op    <= w_op;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_div0  <= w_start_div0;
                        r_wk_hi <= '0;
                        // divide-by-zero keeps raw A here so FIXUP can return it in Hi
                        r_wk_lo <= w_start_div0 ? A : w_a_mag;
                        r_opb   <= w_b_mag;
                        r_cnt   <= w_cnt_init;
                        r_dbz   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= w_start_div0 ? FIXUP : CALC;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    if (Flush) begin
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_wk_hi <= w_step_hi;
                        r_wk_lo <= w_step_lo;
                        r_cnt   <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1))
                            r_state <= FIXUP;
                    end
                end
                FIXUP: begin
                    r_busy <= 1'b0;
                    if (Flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_hi    <= w_res[2*WIDTH-1:WIDTH];
                        r_lo    <= w_res[WIDTH-1:0];
                        r_dbz   <= r_div0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
